// File: rtl/ext_mem_pkg.sv
// Shared types and constants for the external-memory responder slice.
// EXT_MEM_ACCESS_COUNT_EN (optional) adds access counters to ext_mem_responder.
package ext_mem_pkg;

    localparam logic [31:0] EXT_MEM_BASE_DEFAULT = 32'h0010_0000;
    localparam logic [31:0] ERR_DATA             = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP,
        ST_DONE
    } state_e;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } op_e;

    // 33-bit compare so a window ending at 4 GiB cannot wrap to zero
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input int unsigned depth_words);
        logic [32:0] lim;
        lim = {1'b0, base} + ({1'b0, depth_words} << 2);
        return ({1'b0, addr} >= {1'b0, base}) && ({1'b0, addr} < lim);
    endfunction

endpackage

// File: rtl/ext_mem_responder_if.sv
// Initiator/responder handshake bundle for the external memory region.
interface ext_mem_responder_if;

    logic [31:0] ext_addr;
    logic [31:0] ext_wdata;
    logic [31:0] ext_rdata;
    logic        ext_rdata_oe;
    logic        ext_mem_read;
    logic        ext_mem_write;
    logic        ext_mem_enable;
    logic        ext_mem_ready;
    logic        bus_error;

    modport master (
        output ext_addr, ext_wdata, ext_mem_read, ext_mem_write, ext_mem_enable,
        input  ext_rdata, ext_rdata_oe, ext_mem_ready, bus_error
    );

    modport slave (
        input  ext_addr, ext_wdata, ext_mem_read, ext_mem_write, ext_mem_enable,
        output ext_rdata, ext_rdata_oe, ext_mem_ready, bus_error
    );

endinterface

// File: rtl/ext_mem_array.sv
// Word storage: one synchronous write port, one registered read port.
// Contents are never reset; only the read register clears on rst_n.
module ext_mem_array #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned IDX_W       = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we_i,
    input  logic [IDX_W-1:0] widx_i,
    input  logic [31:0]      wdata_i,
    input  logic             re_i,
    input  logic [IDX_W-1:0] ridx_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[widx_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[ridx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ext_mem_responder.sv
// External memory responder: wait-state FSM, range checking and word storage.
// Define EXT_MEM_ACCESS_COUNT_EN to add the rd_count/wr_count outputs.
module ext_mem_responder
    import ext_mem_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = EXT_MEM_BASE_DEFAULT,
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    ext_mem_responder_if.slave ext_bus
`ifdef EXT_MEM_ACCESS_COUNT_EN
    ,
    output logic [31:0]        rd_count,
    output logic [31:0]        wr_count
`endif
);

    localparam int unsigned IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_STATES - 1);

    state_e           state_q;
    logic [3:0]       cnt_q;
    logic             ready_q;
    logic             berr_q;
    logic             oe_q;
    logic             err_rd_q;
    logic [IDX_W-1:0] idx_q;
    logic [31:0]      wdata_q;
    op_e              op_q;
    logic             err_q;

    logic             req_live;
    logic             live_rd;
    logic             live_err;
    op_e              live_op;
    logic [IDX_W-1:0] live_idx;
    logic             accept;
    logic             to_resp_idle;
    logic             to_resp_wait;
    logic             enter_resp;
    logic             resp_err;
    logic             resp_rd;
    logic             arr_re;
    logic             arr_we;
    logic [IDX_W-1:0] arr_ridx;
    logic [31:0]      arr_rdata;

    assign req_live = ext_bus.ext_mem_read | ext_bus.ext_mem_write;
    assign live_rd  = ext_bus.ext_mem_read & ~ext_bus.ext_mem_write;
    assign live_op  = live_rd ? OP_READ : OP_WRITE;
    // Simultaneous read and write is rejected like an out-of-range access
    assign live_err = !addr_in_range(ext_bus.ext_addr, ADDR_BASE, DEPTH_WORDS)
                      || (ext_bus.ext_mem_read && ext_bus.ext_mem_write);
    assign live_idx = IDX_W'((ext_bus.ext_addr - ADDR_BASE) >> 2);

    assign accept       = (state_q == ST_IDLE) && ext_bus.ext_mem_enable && req_live;
    assign to_resp_idle = accept && (WAIT_STATES == 0);
    assign to_resp_wait = (state_q == ST_WAIT) && req_live && (cnt_q == 4'd0);
    assign enter_resp   = to_resp_idle || to_resp_wait;
    assign resp_err     = to_resp_idle ? live_err : err_q;
    assign resp_rd      = to_resp_idle ? live_rd  : (op_q == OP_READ);

    // Read port fires on the edge entering RESP; with no wait states the live address is used
    assign arr_re   = enter_resp && resp_rd && !resp_err;
    assign arr_ridx = (state_q == ST_IDLE) ? live_idx : idx_q;
    assign arr_we   = (state_q == ST_RESP) && (op_q == OP_WRITE) && !err_q;

    always_ff @(posedge clk) begin
        if (accept) begin
            idx_q   <= live_idx;
            wdata_q <= ext_bus.ext_wdata;
            op_q    <= live_op;
            err_q   <= live_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            ready_q  <= 1'b0;
            berr_q   <= 1'b0;
            oe_q     <= 1'b0;
            err_rd_q <= 1'b0;
`ifdef EXT_MEM_ACCESS_COUNT_EN
            rd_count <= 32'd0;
            wr_count <= 32'd0;
`endif
        end else begin
            ready_q <= 1'b0;
            berr_q  <= 1'b0;
            oe_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (WAIT_STATES == 0) begin
                            state_q <= ST_RESP;
                        end else begin
                            state_q <= ST_WAIT;
                            cnt_q   <= WAIT_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!req_live) begin
                        state_q <= ST_IDLE;
                    end else if (cnt_q == 4'd0) begin
                        state_q <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_DONE;
`ifdef EXT_MEM_ACCESS_COUNT_EN
                    if (!err_q) begin
                        if (op_q == OP_READ) begin
                            rd_count <= rd_count + 32'd1;
                        end else begin
                            wr_count <= wr_count + 32'd1;
                        end
                    end
`endif
                end
                ST_DONE: begin
                    // Wait for the initiator to drop a held request
                    if (!req_live) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
            if (enter_resp) begin
                ready_q <= 1'b1;
                berr_q  <= resp_err;
                oe_q    <= resp_rd;
                if (resp_rd) begin
                    err_rd_q <= resp_err;
                end
            end
        end
    end

    ext_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (arr_we),
        .widx_i  (idx_q),
        .wdata_i (wdata_q),
        .re_i    (arr_re),
        .ridx_i  (arr_ridx),
        .rdata_o (arr_rdata)
    );

    assign ext_bus.ext_mem_ready = ready_q;
    assign ext_bus.bus_error     = berr_q;
    assign ext_bus.ext_rdata_oe  = oe_q;
    assign ext_bus.ext_rdata     = err_rd_q ? ERR_DATA : arr_rdata;

endmodule

// File: tb/tb_ext_mem_responder.sv
// Directed bench for ext_mem_responder (defaults: base 0x00100000, 4096 words, 2 wait states).
// Counter checks are compiled in when EXT_MEM_ACCESS_COUNT_EN is defined.
module tb_ext_mem_responder;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fails;

    ext_mem_responder_if bus ();

`ifdef EXT_MEM_ACCESS_COUNT_EN
    logic [31:0] rd_count;
    logic [31:0] wr_count;
`endif

    ext_mem_responder dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ext_bus (bus)
`ifdef EXT_MEM_ACCESS_COUNT_EN
        ,
        .rd_count (rd_count),
        .wr_count (wr_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_bus();
        bus.ext_mem_enable = 1'b0;
        bus.ext_mem_read   = 1'b0;
        bus.ext_mem_write  = 1'b0;
    endtask

    // lat counts edges from the accepting edge (=1) to the edge on which ready is sampled
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input int hold, input bit no_sync,
                             output int lat, output logic berr, output logic [31:0] rdata,
                             output int rdy_cnt, output int oe_cnt);
        if (!no_sync) @(negedge clk);
        bus.ext_addr       = addr;
        bus.ext_wdata      = wdata;
        bus.ext_mem_read   = rd;
        bus.ext_mem_write  = wr;
        bus.ext_mem_enable = 1'b1;
        lat = -1; berr = 1'b0; rdata = '0; rdy_cnt = 0; oe_cnt = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (bus.ext_mem_ready) begin
                rdy_cnt++;
                if (lat < 0) begin
                    lat   = i;
                    berr  = bus.bus_error;
                    rdata = bus.ext_rdata;
                end
            end
            if (bus.ext_rdata_oe) oe_cnt++;
            if (lat > 0 && i >= lat + hold) break;
        end
        @(negedge clk);
        idle_bus();
        repeat (2) @(posedge clk);
    endtask

    int          lat, rdy, oe, pulses;
    logic        berr;
    logic [31:0] rdata;

    initial begin
        n_tests = 0;
        n_fails = 0;
        rst_n   = 1'b0;
        idle_bus();
        bus.ext_addr  = '0;
        bus.ext_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, bus.ext_mem_ready}, 32'd0);
        check("rst_berr",  {31'd0, bus.bus_error},     32'd0);
        check("rst_oe",    {31'd0, bus.ext_rdata_oe},  32'd0);
        check("rst_rdata", bus.ext_rdata,              32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Write then read back with 2 wait states
        do_access(1'b0, 1'b1, 32'h0010_0010, 32'hCAFE_F00D, 2, 1'b0, lat, berr, rdata, rdy, oe);
        check("wr_lat",  lat, 32'd3);
        check("wr_berr", {31'd0, berr}, 32'd0);
        check("wr_rdy",  rdy, 32'd1);
        check("wr_oe",   oe,  32'd0);
        do_access(1'b1, 1'b0, 32'h0010_0010, 32'h0, 2, 1'b0, lat, berr, rdata, rdy, oe);
        check("rd_lat",   lat, 32'd3);
        check("rd_berr",  {31'd0, berr}, 32'd0);
        check("rd_data",  rdata, 32'hCAFE_F00D);
        check("rd_oe",    oe, 32'd1);
        check("rd_rdy",   rdy, 32'd1);
        check("rd_hold",  bus.ext_rdata, 32'hCAFE_F00D);
        check("rd_oe_lo", {31'd0, bus.ext_rdata_oe}, 32'd0);

        // Range boundaries: last word, one past the end, one below the base
        do_access(1'b0, 1'b1, 32'h0010_3FFC, 32'h1234_5678, 0, 1'b0, lat, berr, rdata, rdy, oe);
        check("last_wr_berr", {31'd0, berr}, 32'd0);
        do_access(1'b1, 1'b0, 32'h0010_4000, 32'h0, 2, 1'b0, lat, berr, rdata, rdy, oe);
        check("oor_lat",  lat, 32'd3);
        check("oor_berr", {31'd0, berr}, 32'd1);
        check("oor_data", rdata, 32'hDEAD_BEEF);
        do_access(1'b1, 1'b0, 32'h0010_3FFC, 32'h0, 0, 1'b0, lat, berr, rdata, rdy, oe);
        check("last_berr", {31'd0, berr}, 32'd0);
        check("last_data", rdata, 32'h1234_5678);
        do_access(1'b1, 1'b0, 32'h000F_FFFC, 32'h0, 0, 1'b0, lat, berr, rdata, rdy, oe);
        check("below_berr", {31'd0, berr}, 32'd1);
        check("below_data", rdata, 32'hDEAD_BEEF);

        // Read and write asserted together is an error and leaves the word alone
        do_access(1'b0, 1'b1, 32'h0010_0000, 32'hA5A5_A5A5, 0, 1'b0, lat, berr, rdata, rdy, oe);
        do_access(1'b1, 1'b1, 32'h0010_0000, 32'h1111_1111, 0, 1'b0, lat, berr, rdata, rdy, oe);
        check("rw_lat",  lat, 32'd3);
        check("rw_berr", {31'd0, berr}, 32'd1);
        do_access(1'b1, 1'b0, 32'h0010_0000, 32'h0, 0, 1'b0, lat, berr, rdata, rdy, oe);
        check("rw_after", rdata, 32'hA5A5_A5A5);

        // Abort: write dropped after one WAIT cycle
        do_access(1'b0, 1'b1, 32'h0010_0020, 32'h55AA_55AA, 0, 1'b0, lat, berr, rdata, rdy, oe);
        @(negedge clk);
        bus.ext_addr = 32'h0010_0020; bus.ext_wdata = 32'hFFFF_FFFF;
        bus.ext_mem_write = 1'b1; bus.ext_mem_enable = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        idle_bus();
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.ext_mem_ready) pulses++;
        end
        check("abort_rdy", pulses, 32'd0);
        // Held request: one ready pulse, and normal latency proves the FSM went back to IDLE
        do_access(1'b1, 1'b0, 32'h0010_0020, 32'h0, 5, 1'b0, lat, berr, rdata, rdy, oe);
        check("abort_lat",  lat, 32'd3);
        check("abort_data", rdata, 32'h55AA_55AA);
        check("held_rdy",   rdy, 32'd1);
        check("held_oe",    oe,  32'd1);

        // Reset in the middle of a write's WAIT phase
        do_access(1'b0, 1'b1, 32'h0010_0030, 32'h1357_9BDF, 0, 1'b0, lat, berr, rdata, rdy, oe);
        do_access(1'b1, 1'b0, 32'h0010_0010, 32'h0, 0, 1'b0, lat, berr, rdata, rdy, oe);
        @(negedge clk);
        bus.ext_addr = 32'h0010_0030; bus.ext_wdata = 32'hFFFF_0000;
        bus.ext_mem_write = 1'b1; bus.ext_mem_enable = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_ready", {31'd0, bus.ext_mem_ready}, 32'd0);
        check("mrst_berr",  {31'd0, bus.bus_error},     32'd0);
        check("mrst_oe",    {31'd0, bus.ext_rdata_oe},  32'd0);
        check("mrst_rdata", bus.ext_rdata,              32'd0);
        idle_bus();
        @(negedge clk);
        rst_n = 1'b1;
        do_access(1'b1, 1'b0, 32'h0010_0030, 32'h0, 0, 1'b1, lat, berr, rdata, rdy, oe);
        check("post_rst_lat",  lat, 32'd3);
        check("post_rst_data", rdata, 32'h1357_9BDF);

`ifdef EXT_MEM_ACCESS_COUNT_EN
        // One good read already done since reset; add 2 reads, 2 writes, 1 error
        do_access(1'b1, 1'b0, 32'h0010_0000, 32'h0, 0, 1'b0, lat, berr, rdata, rdy, oe);
        do_access(1'b0, 1'b1, 32'h0010_0040, 32'h0000_0001, 0, 1'b0, lat, berr, rdata, rdy, oe);
        do_access(1'b1, 1'b0, 32'h0010_0040, 32'h0, 0, 1'b0, lat, berr, rdata, rdy, oe);
        do_access(1'b0, 1'b1, 32'h0010_0044, 32'h0000_0002, 0, 1'b0, lat, berr, rdata, rdy, oe);
        do_access(1'b0, 1'b1, 32'h0020_0000, 32'h0000_0003, 0, 1'b0, lat, berr, rdata, rdy, oe);
        check("rd_count", rd_count, 32'd3);
        check("wr_count", wr_count, 32'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule
